// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, register-zero constant,
// counter width default and the source/destination register match helper.
package pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } hdu_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         CNT_W_DEFAULT = 16;

  // r0 is hardwired to zero, so it never creates a dependence
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_detect_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && !(&count_q))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign cnt_o = count_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// Stall/flush controller beside ID: freezes PC and IF/ID and bubbles ID/EX on hazards
// forwarding cannot cover, flushes IF/ID on taken branches/jumps, counts stalls and flushes.
module hazard_detect_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WR_out,
  input  logic             M_MemRead,
  input  logic [4:0]       M_WR_out,
  input  logic             ext_stall,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             ID_EX_Bubble,
  output logic             IF_Flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hdu_state_e state_q;

  logic dep_ex, dep_m;
  logic lu, ba, bl2, bl1, haz, stall, flush;

  assign dep_ex = reg_match(ID_Rs, EX_WR_out) || (ID_UsesRt && reg_match(ID_Rt, EX_WR_out));
  assign dep_m  = reg_match(ID_Rs, M_WR_out)  || (ID_UsesRt && reg_match(ID_Rt, M_WR_out));

  assign lu  = EX_MemRead && dep_ex;
  assign ba  = ID_Branch && EX_RegWrite && !EX_MemRead && dep_ex;
  assign bl2 = ID_Branch && EX_MemRead && dep_ex;
  assign bl1 = ID_Branch && M_MemRead && dep_m;

  assign haz   = (state_q == HOLD1) || lu || ba || bl2 || bl1;
  assign stall = haz || ext_stall;
  // Branch operands are stale while stalled, so a flush waits for the first free cycle
  assign flush = !stall && ((ID_Branch && ID_BranchTaken) || ID_Jump);

  always_comb begin
    PCWrite      = !stall;
    IF_IDWrite   = !stall;
    ID_EX_Bubble = haz;
    IF_Flush     = flush;
    if (rst) begin
      PCWrite      = 1'b0;
      IF_IDWrite   = 1'b0;
      ID_EX_Bubble = 1'b1;
      IF_Flush     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (bl2) state_q <= HOLD1;
        HOLD1:   if (!ext_stall) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (haz),
    .clr   (rst),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (IF_Flush),
    .clr   (rst),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scenario bench for hazard_detect_unit: expected control vectors are queued as each
// cycle is driven and popped at the following negative edge.
module tb_hazard_detect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0;
  logic        ID_UsesRt = 0, ID_Branch = 0, ID_BranchTaken = 0, ID_Jump = 0;
  logic        EX_MemRead = 0, EX_RegWrite = 0;
  logic [4:0]  EX_WR_out = '0;
  logic        M_MemRead = 0;
  logic [4:0]  M_WR_out = '0;
  logic        ext_stall = 0;
  logic        PCWrite, IF_IDWrite, ID_EX_Bubble, IF_Flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        PCWrite4, IF_IDWrite4, ID_EX_Bubble4, IF_Flush4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_stall = 0;
  logic [15:0] exp_flush = 0;
  logic [3:0]  exp_q[$];

  typedef struct packed {
    logic       r;
    logic [4:0] rs, rt;
    logic       ur, br, tk, jmp, exmr, exrw;
    logic [4:0] exwr;
    logic       mmr;
    logic [4:0] mwr;
    logic       ext;
    logic [3:0] exp;
  } stim_t;

  always #5 clk = ~clk;

  hazard_detect_unit dut (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WR_out(EX_WR_out),
    .M_MemRead(M_MemRead), .M_WR_out(M_WR_out), .ext_stall(ext_stall),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_Flush(IF_Flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_detect_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WR_out(EX_WR_out),
    .M_MemRead(M_MemRead), .M_WR_out(M_WR_out), .ext_stall(ext_stall),
    .PCWrite(PCWrite4), .IF_IDWrite(IF_IDWrite4), .ID_EX_Bubble(ID_EX_Bubble4),
    .IF_Flush(IF_Flush4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // Vector order: {PCWrite, IF_IDWrite, ID_EX_Bubble, IF_Flush}
  function automatic logic [3:0] obs();
    return {PCWrite, IF_IDWrite, ID_EX_Bubble, IF_Flush};
  endfunction

  function automatic stim_t S(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic br, input logic tk, input logic jmp,
                              input logic exmr, input logic exrw, input logic [4:0] exwr,
                              input logic mmr, input logic [4:0] mwr, input logic ext,
                              input logic [3:0] exp);
    stim_t s;
    s.r = r; s.rs = rs; s.rt = rt; s.ur = ur; s.br = br; s.tk = tk; s.jmp = jmp;
    s.exmr = exmr; s.exrw = exrw; s.exwr = exwr; s.mmr = mmr; s.mwr = mwr; s.ext = ext;
    s.exp = exp;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.r; ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRt = s.ur; ID_Branch = s.br;
    ID_BranchTaken = s.tk; ID_Jump = s.jmp; EX_MemRead = s.exmr; EX_RegWrite = s.exrw;
    EX_WR_out = s.exwr; M_MemRead = s.mmr; M_WR_out = s.mwr; ext_stall = s.ext;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [3:0] got, want;
    apply(S(1, 0,0,0,0,0,0, 0,0,0, 0,0, 0, 4'b0010));
    @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", got, want); end
    @(posedge clk); #1;
    exp_stall = 0; exp_flush = 0;
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    logic [3:0] got, want;
    seq.push_back(S(0, 8,0,0,0,0,0, 1,1,8, 0,0, 0, 4'b0010));
    seq.push_back(S(0, 8,0,0,0,0,0, 0,0,0, 1,8, 0, 4'b1100));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL load_use step%0d got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
    exp_stall += 1;
    n_checks++;
    if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL load_use_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_branch_load();
    stim_t seq[$];
    logic [3:0] got, want;
    seq.push_back(S(0, 3,9,1,1,0,0, 1,1,9, 0,0, 0, 4'b0010));
    seq.push_back(S(0, 3,9,1,1,0,0, 0,0,0, 1,9, 0, 4'b0010));
    seq.push_back(S(0, 3,9,1,1,1,0, 0,0,0, 0,0, 0, 4'b1101));
    seq.push_back(S(0, 0,0,0,0,0,0, 0,0,0, 0,0, 0, 4'b1100));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL branch_load step%0d got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
    exp_stall += 2; exp_flush += 1;
    n_checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      n_fail++; $display("FAIL branch_load_cnt got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_no_false();
    stim_t seq[$];
    logic [3:0] got, want;
    seq.push_back(S(0, 0,0,0,0,0,0, 1,1,0, 0,0, 0, 4'b1100));
    seq.push_back(S(0, 3,8,0,0,0,0, 1,1,8, 0,0, 0, 4'b1100));
    seq.push_back(S(0, 5,0,0,0,0,0, 0,1,5, 0,0, 0, 4'b1100));
    seq.push_back(S(0, 0,0,1,1,0,0, 0,1,0, 1,0, 0, 4'b1100));
    seq.push_back(S(0, 4,0,0,0,0,0, 0,0,0, 1,4, 0, 4'b1100));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL no_false step%0d got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL no_false_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_stall_over_flush();
    stim_t seq[$];
    logic [3:0] got, want;
    seq.push_back(S(0, 5,0,0,1,1,0, 0,1,5, 0,0, 0, 4'b0010));
    seq.push_back(S(0, 5,0,0,1,1,0, 0,0,0, 0,0, 0, 4'b1101));
    seq.push_back(S(0, 0,0,0,0,0,1, 0,0,0, 0,0, 1, 4'b0000));
    seq.push_back(S(0, 0,0,0,0,0,1, 0,0,0, 0,0, 0, 4'b1101));
    seq.push_back(S(0, 0,0,0,1,0,0, 0,0,0, 0,0, 0, 4'b1100));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL stall_over_flush step%0d got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
    exp_stall += 1; exp_flush += 2;
    n_checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      n_fail++; $display("FAIL stall_over_flush_cnt got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_ext_hold();
    stim_t seq[$];
    logic [3:0] got, want;
    int pc_low = 0;
    seq.push_back(S(0, 9,0,0,1,0,0, 1,1,9, 0,0, 0, 4'b0010));
    for (int k = 0; k < 3; k++) seq.push_back(S(0, 9,0,0,1,0,0, 0,0,0, 1,9, 1, 4'b0010));
    seq.push_back(S(0, 9,0,0,1,0,0, 0,0,0, 1,9, 0, 4'b0010));
    seq.push_back(S(0, 9,0,0,1,0,0, 0,0,0, 0,0, 0, 4'b1100));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
      if (!PCWrite) pc_low++;
      if (got !== want) begin n_fail++; $display("FAIL ext_hold step%0d got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
    exp_stall += 5;
    n_checks++;
    if (pc_low != 5) begin n_fail++; $display("FAIL ext_hold_pclow got=%0d want=5", pc_low); end
    n_checks++;
    if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL ext_hold_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_reset_hold();
    logic [3:0] got, want;
    apply(S(0, 7,0,0,1,0,0, 1,1,7, 0,0, 0, 4'b0010));
    @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_hold_enter got=%b want=%b", got, want); end
    @(posedge clk); #1;
    apply(S(1, 0,0,0,0,0,0, 0,0,0, 0,0, 0, 4'b0010));
    @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_hold_rst got=%b want=%b", got, want); end
    @(posedge clk); #1;
    exp_stall = 0; exp_flush = 0;
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      n_fail++; $display("FAIL reset_hold_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, stall_cnt4);
    end
    apply(S(0, 0,0,0,0,0,0, 0,0,0, 0,0, 0, 4'b1100));
    @(negedge clk); got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_hold_run got=%b want=%b", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [3:0] got, want;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      apply(S(0, 6,0,0,0,0,0, 1,1,6, 0,0, 0, 4'b0010));
      @(negedge clk); got = obs(); want = exp_q.pop_front();
      if (got !== want) bad++;
      @(posedge clk); #1;
    end
    exp_stall += 20;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL saturation_outputs bad_cycles=%0d want=0", bad); end
    n_checks++;
    if (stall_cnt4 !== 4'd15) begin n_fail++; $display("FAIL saturation_cnt4 got=%0d want=15", stall_cnt4); end
    n_checks++;
    if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL saturation_cnt16 got=%0d want=%0d", stall_cnt, exp_stall); end
    apply(S(0, 0,0,0,0,0,0, 0,0,0, 0,0, 0, 4'b1100));
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    n_checks++;
    if (stall_cnt4 !== 4'd15) begin n_fail++; $display("FAIL saturation_hold got=%0d want=15", stall_cnt4); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_no_false();
    test_stall_over_flush();
    test_ext_hold();
    test_reset_hold();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Stall/flush controller for the 5-stage MIPS pipeline, the control-side counterpart to forwarding: where forwarding fixes dependences by routing data, this unit handles the ones forwarding cannot. It resolves load-use hazards and ID-stage branch-operand hazards by freezing PC and IF/ID and inserting an ID/EX bubble. It flushes IF/ID on taken branches and jumps resolved in ID. It sits beside the ID stage and also keeps saturating stall/flush performance counters.

## Interface
- `CNT_W`, default 16, width of the performance counters.
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — synchronous reset, active-high.
- `ID_Rs`, `ID_Rt` input 5 each — source registers of the instruction in ID.
- `ID_UsesRt` input 1 — the ID instruction reads Rt as a source (R-type, store, branch).
- `ID_Branch` input 1 — beq/bne in ID; operands are compared in ID.
- `ID_BranchTaken` input 1 — ID comparator result; valid only when `ID_Branch`.
- `ID_Jump` input 1 — j/jal/jr in ID.
- `EX_MemRead`, `EX_RegWrite` input 1 each; `EX_WR_out` input 5 — destination of the instruction in EX.
- `M_MemRead` input 1; `M_WR_out` input 5 — destination of the instruction in MEM.
- `ext_stall` input 1 — data-memory wait request; freezes the whole front end.
- `PCWrite` output 1 — PC update enable.
- `IF_IDWrite` output 1 — IF/ID register write enable.
- `ID_EX_Bubble` output 1 — zero the ID/EX control fields.
- `IF_Flush` output 1 — clear IF/ID (insert nop).
- `stall_cnt`, `flush_cnt` output `CNT_W` each — counts of stall cycles and of flush events.

## Operation
- Register r0 never matches. A match means the source register is nonzero and equals the destination.
- `dep(X)` is true when `X==ID_Rs`, or when `ID_UsesRt && X==ID_Rt`.
- Load-use hazard (`lu`): `EX_MemRead && dep(EX_WR_out)`. Needs 1 stall cycle.
- Branch-ALU hazard (`ba`): `ID_Branch && EX_RegWrite && !EX_MemRead && dep(EX_WR_out)`. Needs 1 stall cycle.
- Branch-load hazard (`bl2`): `ID_Branch && EX_MemRead && dep(EX_WR_out)`. Needs 2 stall cycles.
- Branch-load-in-MEM hazard (`bl1`): `ID_Branch && M_MemRead && dep(M_WR_out)`. Needs 1 stall cycle.
- FSM with states RUN and HOLD1:
  - In RUN, `bl2` moves to HOLD1. Any other hazard stays in RUN.
  - HOLD1 forces a stall for one cycle regardless of inputs, then returns to RUN.
- `haz = (state==HOLD1) || lu || ba || bl2 || bl1`.
- Stall (`haz || ext_stall`) drives `PCWrite=0` and `IF_IDWrite=0`.
- Hazard stall drives `ID_EX_Bubble=1`.
- `ext_stall` alone drives `ID_EX_Bubble=0`. It freezes the front end only; the back end holds itself.
- Flush: `IF_Flush = !haz && !ext_stall && ((ID_Branch && ID_BranchTaken) || ID_Jump)`.
  - While stalled, the branch operands are stale, so no flush occurs.
  - The flush fires on the first non-stalled cycle.
- Flush and stall are therefore never asserted together.
- `ext_stall` arriving in HOLD1 does not advance the FSM: state stays HOLD1 until a cycle with `!ext_stall`.
- Counters:
  - `stall_cnt` increments on every cycle with `haz`.
  - `flush_cnt` increments on every cycle with `IF_Flush`.
  - Both saturate at all-ones; there is no wrap-around.

## Timing
- Hazard detection and `PCWrite`/`IF_IDWrite`/`ID_EX_Bubble`/`IF_Flush` are combinational from the inputs plus the state, in the same cycle.
- The FSM and counters update on the rising edge of `clk`.
- While `rst`=1:
  - `PCWrite=0`, `IF_IDWrite=0`, `ID_EX_Bubble=1`, `IF_Flush=0`.
  - On the next edge: state←RUN, both counters←0.
- Reset mid-HOLD1 abandons the hold; the first post-reset cycle is in RUN.
- Stall latency: the `lu` hazard gives exactly 1 bubble and the dependent instruction issues the following cycle. `bl2` gives exactly 2 consecutive stall cycles (RUN→HOLD1→RUN), plus any `ext_stall` cycles.

## Structure
- Shared package (`pipe_pkg`) holds:
  - the FSM state encoding (RUN=1'b0, HOLD1=1'b1);
  - the constant `REG_ZERO=5'd0`;
  - the `CNT_W` default.
- One sub-module, `sat_counter`, parameterised by width, with inputs `inc` and `clr`. It is instantiated twice.
- The hazard equations and FSM live in the top module.

## Test plan
- Load-use: EX lw with `EX_WR_out`=8; ID add with Rs=8 → one cycle of `PCWrite=0`, `IF_IDWrite=0`, `ID_EX_Bubble=1`; then release; `stall_cnt`=1.
- Branch after load: EX lw to $9; ID beq on Rt=9 with `ID_UsesRt`=1 → stall for 2 consecutive cycles (second in HOLD1); next cycle with `ID_BranchTaken`=1 → `IF_Flush`=1; counters then read `stall_cnt`=2 and `flush_cnt`=1.
- r0 and no-false-hazard cases: EX lw to $0 with ID Rs=0 → no stall. ID Rt match with `ID_UsesRt`=0 → no stall.
- Stall-over-flush: `ba` hazard with `ID_BranchTaken`=1 in the same cycle → `IF_Flush`=0; flush is asserted the next cycle.
- ext_stall during HOLD1: `ext_stall`=1 for 3 cycles after entering HOLD1 → state held; `PCWrite` low for 5 cycles total; `stall_cnt` +5.
- Reset and saturation:
  - Assert `rst` while in HOLD1 → state RUN and both counters 0 on the next edge.
  - Preload `stall_cnt` near max with `CNT_W`=4 and run 20 stall cycles → `stall_cnt` holds at 15.
